// File: rtl/iob_sram_resp.sv
// IOb bus responder driving a single-port synchronous SRAM, with optional wait states.
// Read data returns 3+WAIT_CYCLES cycles after accept; a write acks by raising ready at 2+WAIT_CYCLES.
// One request in flight at a time: ready is low while busy, and cke_i low freezes all state.
// Optional address range checking is enabled by defining IOB_SRAM_RESP_ADDR_CHECK_EN.
module iob_sram_resp #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_ADDR_W  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic                    cke_i,
    input  logic                    iob_valid_i,
    input  logic [ADDR_W-1:0]       iob_addr_i,
    input  logic [DATA_W-1:0]       iob_wdata_i,
    input  logic [DATA_W/8-1:0]     iob_wstrb_i,
    output logic [DATA_W-1:0]       iob_rdata_o,
    output logic                    iob_rvalid_o,
    output logic                    iob_ready_o,
    output logic                    sram_en_o,
    output logic [DATA_W/8-1:0]     sram_we_o,
    output logic [MEM_ADDR_W-1:0]   sram_addr_o,
    output logic [DATA_W-1:0]       sram_wdata_o,
    input  logic [DATA_W-1:0]       sram_rdata_i,
    output logic                    err_o
);

    localparam int STRB_W = DATA_W / 8;
    // The counter holds the number of remaining WAIT cycles minus one.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        MEM   = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic [MEM_ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic                    oor_q;
    logic                    ready_q;
    logic                    en_q;
    logic [STRB_W-1:0]       we_q;
    logic                    rvalid_q;
    logic [DATA_W-1:0]       rdata_q;
    logic                    req_oor;
    logic                    is_write;

    // The byte lane bits are never used: sub-word selection is done by the strobes.
`ifdef IOB_SRAM_RESP_ADDR_CHECK_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^iob_addr_i[1:0];
    assign req_oor = |iob_addr_i[ADDR_W-1:MEM_ADDR_W+2];
`else
    // Upper address bits are dropped, so accesses alias modulo the SRAM depth.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iob_addr_i[ADDR_W-1:MEM_ADDR_W+2], iob_addr_i[1:0]};
    assign req_oor = 1'b0;
`endif

    assign is_write = |wstrb_q;

    // Request FSM: latches the request, counts wait states, issues the SRAM access and returns read data.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            oor_q    <= 1'b0;
            ready_q  <= 1'b1;
            en_q     <= 1'b0;
            we_q     <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (cke_i) begin
            rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (iob_valid_i) begin
                        addr_q  <= iob_addr_i[MEM_ADDR_W+1:2];
                        wdata_q <= iob_wdata_i;
                        wstrb_q <= iob_wstrb_i;
                        oor_q   <= req_oor;
                        ready_q <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= MEM;
                            en_q  <= ~req_oor;
                            we_q  <= req_oor ? '0 : iob_wstrb_i;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= MEM;
                        en_q  <= ~oor_q;
                        we_q  <= oor_q ? '0 : wstrb_q;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                MEM: begin
                    en_q <= 1'b0;
                    we_q <= '0;
                    if (is_write) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        state <= RDATA;
                    end
                end
                RDATA: begin
                    // An out-of-range read never touched the SRAM, so it returns zero.
                    rdata_q  <= oor_q ? '0 : sram_rdata_i;
                    rvalid_q <= 1'b1;
                    ready_q  <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    en_q    <= 1'b0;
                    we_q    <= '0;
                end
            endcase
        end
    end

`ifdef IOB_SRAM_RESP_ADDR_CHECK_EN
    logic err_q;

    // Sticky error flag: set at the end of the MEM cycle of an out-of-range access.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            err_q <= 1'b0;
        end else if (cke_i && (state == MEM) && oor_q) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign iob_ready_o  = ready_q;
    assign iob_rvalid_o = rvalid_q;
    assign iob_rdata_o  = rdata_q;
    assign sram_en_o    = en_q;
    assign sram_we_o    = we_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;

endmodule

// File: tb/tb_iob_sram_resp.sv
// Bench for iob_sram_resp: one instance with no wait states and one with three, sharing stimulus.
// Each instance has its own behavioural SRAM; expected read data is queued per instance.
// Requests are issued only when both instances are idle, unless a scenario says otherwise.
module tb_iob_sram_resp;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        cke;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic [31:0] rdata0, swdata0, srdata0;
    logic        rvalid0, ready0, en0, err0;
    logic [3:0]  we0;
    logic [9:0]  saddr0;

    logic [31:0] rdata3, swdata3, srdata3;
    logic        rvalid3, ready3, en3, err3;
    logic [3:0]  we3;
    logic [9:0]  saddr3;

    logic [31:0] mem0    [0:1023];
    logic [31:0] mem3    [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] exp_q0  [$];
    logic [31:0] exp_q3  [$];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    iob_sram_resp #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(0)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .iob_valid_i(valid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_rdata_o(rdata0), .iob_rvalid_o(rvalid0), .iob_ready_o(ready0),
        .sram_en_o(en0), .sram_we_o(we0), .sram_addr_o(saddr0), .sram_wdata_o(swdata0),
        .sram_rdata_i(srdata0), .err_o(err0)
    );

    iob_sram_resp #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(3)) dut_w3 (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .iob_valid_i(valid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_rdata_o(rdata3), .iob_rvalid_o(rvalid3), .iob_ready_o(ready3),
        .sram_en_o(en3), .sram_we_o(we3), .sram_addr_o(saddr3), .sram_wdata_o(swdata3),
        .sram_rdata_i(srdata3), .err_o(err3)
    );

    // Behavioural synchronous SRAMs with byte write enables
    always @(posedge clk) begin
        if (en0) begin
            for (int b = 0; b < 4; b++)
                if (we0[b]) mem0[saddr0][b*8 +: 8] <= swdata0[b*8 +: 8];
            srdata0 <= mem0[saddr0];
        end
        if (en3) begin
            for (int b = 0; b < 4; b++)
                if (we3[b]) mem3[saddr3][b*8 +: 8] <= swdata3[b*8 +: 8];
            srdata3 <= mem3[saddr3];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Wait (bounded) for a negedge where both instances are ready
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(ready0 && ready3) && n < 30) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 30) begin
            miscompares++;
            $display("FAIL idle_timeout ready0=%0b ready3=%0b want both 1", ready0, ready3);
        end
    endtask

    // Present one request while both are idle; returns #1 after the accepting edge (cycle T+1)
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wait_idle();
        valid = 1'b1;
        addr  = a;
        wdata = d;
        wstrb = s;
        @(posedge clk);
        #1;
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    // Write to both instances and update the bench's reference memory
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        issue(a, d, s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[11:2]][b*8 +: 8] = d[b*8 +: 8];
    endtask

    // Read on the zero-wait instance and check latency and data
    task automatic read0(input logic [31:0] a, input logic [31:0] exp, input string nm);
        int n;
        bit seen;
        logic [31:0] e;
        issue(a, 32'h0, 4'h0);
        exp_q0.push_back(exp);
        n = 0;
        seen = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            if (rvalid0) seen = 1;
        end
        e = exp_q0.pop_front();
        vectors++;
        if (!seen || n != 3) begin
            miscompares++;
            $display("FAIL %s_latency seen=%0b cycles=%0d want 3", nm, seen, n);
        end
        if (seen) begin
            vectors++;
            if (rdata0 !== e) begin
                miscompares++;
                $display("FAIL %s_rdata got %h want %h", nm, rdata0, e);
            end
            vectors++;
            if (ready0 !== 1'b1) begin
                miscompares++;
                $display("FAIL %s_ready_at_rvalid got %0b want 1", nm, ready0);
            end
        end
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        cke    = 1'b1;
        valid  = 1'b0;
        addr   = 32'h0;
        wdata  = 32'h0;
        wstrb  = 4'h0;
        for (int i = 0; i < 1024; i++) begin
            mem0[i]    = 32'h0;
            mem3[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ready0, rvalid0, en0, err0} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl {ready,rvalid,en,err} got %b want 1000", {ready0, rvalid0, en0, err0});
        end
        vectors++;
        if ({rdata0, swdata0, saddr0, we0} !== 78'h0) begin
            miscompares++;
            $display("FAIL reset_data rdata=%h wdata=%h addr=%h we=%h want all 0", rdata0, swdata0, saddr0, we0);
        end
        vectors++;
        if ({ready3, rvalid3, en3, err3} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl_w3 got %b want 1000", {ready3, rvalid3, en3, err3});
        end
    endtask

    task automatic test_write_read();
        wr(32'h10, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        vectors++;
        if ({en0, we0, saddr0, ready0} !== {1'b1, 4'hF, 10'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL wr_mem_cycle en=%0b we=%h addr=%0d ready=%0b want 1 f 4 0", en0, we0, saddr0, ready0);
        end
        vectors++;
        if (swdata0 !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL wr_wdata got %h want cafef00d", swdata0);
        end
        @(negedge clk);
        vectors++;
        if ({ready0, en0, rvalid0} !== 3'b100) begin
            miscompares++;
            $display("FAIL wr_ack {ready,en,rvalid} got %b want 100", {ready0, en0, rvalid0});
        end
        read0(32'h10, 32'hCAFEF00D, "rd_w0");
    endtask

    task automatic test_wait_states();
        logic [8:1] en_h, rv_h, rdy_h;
        issue(32'h10, 32'h0, 4'h0);
        exp_q3.push_back(32'hCAFEF00D);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            en_h[n]  = en3;
            rv_h[n]  = rvalid3;
            rdy_h[n] = ready3;
            if (rvalid3) begin
                vectors++;
                if (rdata3 !== exp_q3[0]) begin
                    miscompares++;
                    $display("FAIL w3_rdata got %h want %h", rdata3, exp_q3[0]);
                end
                void'(exp_q3.pop_front());
            end
        end
        vectors++;
        if (en_h !== 8'b0000_1000) begin
            miscompares++;
            $display("FAIL w3_en_timing got %b want 00001000", en_h);
        end
        vectors++;
        if (rv_h !== 8'b0010_0000) begin
            miscompares++;
            $display("FAIL w3_rvalid_timing got %b want 00100000", rv_h);
        end
        vectors++;
        if (rdy_h !== 8'b1110_0000) begin
            miscompares++;
            $display("FAIL w3_ready_timing got %b want 11100000", rdy_h);
        end
    endtask

    task automatic test_partial_write();
        bit rv_seen;
        wr(32'h20, 32'hAABBCCDD, 4'hF);
        wr(32'h20, 32'h11223344, 4'h3);
        rv_seen = 0;
        @(negedge clk);
        vectors++;
        if ({en0, we0, saddr0} !== {1'b1, 4'h3, 10'd8}) begin
            miscompares++;
            $display("FAIL pw_strobe en=%0b we=%h addr=%0d want 1 3 8", en0, we0, saddr0);
        end
        if (rvalid0) rv_seen = 1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (rvalid0) rv_seen = 1;
        end
        vectors++;
        if (rv_seen) begin
            miscompares++;
            $display("FAIL pw_no_rvalid got 1 want 0");
        end
        read0(32'h20, 32'hAABB3344, "pw_read");
    endtask

    task automatic test_stall_reset();
        logic [16:1] en_h, rv_h;
        // Stall five cycles while the wait-state instance sits in WAIT
        issue(32'h20, 32'h0, 4'h0);
        exp_q3.push_back(32'hAABB3344);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) cke = 1'b0;
            if (n == 6) cke = 1'b1;
            en_h[n] = en3;
            rv_h[n] = rvalid3;
            if (rvalid3 && cke) begin
                vectors++;
                if (rdata3 !== exp_q3[0]) begin
                    miscompares++;
                    $display("FAIL stall_rdata got %h want %h", rdata3, exp_q3[0]);
                end
                void'(exp_q3.pop_front());
            end
        end
        vectors++;
        if (en_h !== 16'h0100) begin
            miscompares++;
            $display("FAIL stall_en_timing got %h want 0100", en_h);
        end
        vectors++;
        if (rv_h !== 16'h0400) begin
            miscompares++;
            $display("FAIL stall_rvalid_timing got %h want 0400", rv_h);
        end

        // Reset asserted while the zero-wait instance is in MEM
        issue(32'h10, 32'h0, 4'h0);
        #1;
        vectors++;
        if (en0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_en got %0b want 1", en0);
        end
        arst_n = 1'b0;
        #1;
        vectors++;
        if ({ready0, rvalid0, en0, we0} !== 7'b100_0000) begin
            miscompares++;
            $display("FAIL rst_mid_ctrl {ready,rvalid,en,we} got %b want 1000000", {ready0, rvalid0, en0, we0});
        end
        vectors++;
        if ({rdata0, saddr0} !== 42'h0) begin
            miscompares++;
            $display("FAIL rst_mid_data rdata=%h addr=%h want 0", rdata0, saddr0);
        end
        @(negedge clk);
        arst_n = 1'b1;
        begin
            bit bad;
            bad = 0;
            for (int n = 0; n < 6; n++) begin
                @(negedge clk);
                if (rvalid0 || en0 || rvalid3 || en3) bad = 1;
            end
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL rst_dropped got activity after reset want none");
            end
        end
    endtask

    task automatic test_addr_check();
        logic        exp_en;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        bit          seen;
`ifdef IOB_SRAM_RESP_ADDR_CHECK_EN
        exp_en  = 1'b0;
        exp_rd  = 32'h0;
        exp_err = 1'b1;
`else
        exp_en  = 1'b1;
        exp_rd  = 32'h12345678;
        exp_err = 1'b0;
`endif
        wr(32'h0, 32'h12345678, 4'hF);
        issue(32'h0000_1000, 32'h0, 4'h0);
        exp_q0.push_back(exp_rd);
        @(negedge clk);
        vectors++;
        if ({en0, err0} !== {exp_en, 1'b0}) begin
            miscompares++;
            $display("FAIL oor_mem_cycle {en,err} got %b want %b", {en0, err0}, {exp_en, 1'b0});
        end
        n = 1;
        seen = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            if (rvalid0) seen = 1;
        end
        vectors++;
        if (!seen || n != 3) begin
            miscompares++;
            $display("FAIL oor_latency seen=%0b cycles=%0d want 3", seen, n);
        end
        vectors++;
        if (rdata0 !== exp_q0[0]) begin
            miscompares++;
            $display("FAIL oor_rdata got %h want %h", rdata0, exp_q0[0]);
        end
        void'(exp_q0.pop_front());
        repeat (3) @(negedge clk);
        vectors++;
        if (err0 !== exp_err) begin
            miscompares++;
            $display("FAIL oor_err_sticky got %0b want %0b", err0, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        logic        rdy;
        int          i, got, last, cyc;
        base = 32'h40;
        for (int k = 0; k < 4; k++) wr(base + 32'(k * 4), $urandom, 4'hF);
        wait_idle();
        i = 0;
        got = 0;
        last = 0;
        cyc = 0;
        valid = 1'b1;
        addr  = base;
        wstrb = 4'h0;
        exp_q0.push_back(ref_mem[base[11:2]]);
        while (got < 4 && cyc < 60) begin
            rdy = ready0;
            @(posedge clk);
            #1;
            if (rdy && valid) begin
                i++;
                if (i < 4) begin
                    addr = base + 32'(i * 4);
                    exp_q0.push_back(ref_mem[addr[11:2]]);
                end else begin
                    valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
            if (rvalid0) begin
                vectors++;
                if (rdata0 !== exp_q0[0]) begin
                    miscompares++;
                    $display("FAIL b2b_rdata[%0d] got %h want %h", got, rdata0, exp_q0[0]);
                end
                void'(exp_q0.pop_front());
                if (got > 0) begin
                    vectors++;
                    if (cyc - last != 3) begin
                        miscompares++;
                        $display("FAIL b2b_spacing[%0d] got %0d want 3", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
        end
        valid = 1'b0;
        vectors++;
        if (got != 4) begin
            miscompares++;
            $display("FAIL b2b_count got %0d want 4", got);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_partial_write();
        test_stall_reset();
        test_addr_check();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iob_sram_resp.md
# iob_sram_resp

IOb-native bus responder that serves a CPU data- or instruction-bus port from a single-port synchronous SRAM. It sits between a bus initiator (CPU core wrapper or interconnect slave port) and an SRAM macro. It latches each accepted request, inserts a configurable number of wait states and drives the SRAM. For reads it returns data with a one-cycle `rvalid` pulse; for writes it completes silently, with `ready` re-assertion acting as the write acknowledge.

## Interface
Parameters:
- `DATA_W`, 32: bus and SRAM data width; `DATA_W/8` strobe bits.
- `ADDR_W`, 32: bus byte-address width.
- `MEM_ADDR_W`, 10: SRAM word-address width; depth `2**MEM_ADDR_W` words.
- `WAIT_CYCLES`, 0: wait states inserted before each SRAM access, range 0..15.

Ports:
- `clk_i` in 1: clock.
- `arst_n_i` in 1: reset, asynchronous, active-low.
- `cke_i` in 1: clock enable; when low, all state is frozen.
- `iob_valid_i` in 1: request valid.
- `iob_addr_i` in `ADDR_W`: byte address.
- `iob_wdata_i` in `DATA_W`: write data.
- `iob_wstrb_i` in `DATA_W/8`: byte strobes; nonzero means write, zero means read.
- `iob_rdata_o` out `DATA_W`: read data, registered.
- `iob_rvalid_o` out 1: read data valid, one-cycle pulse.
- `iob_ready_o` out 1: responder can accept a request.
- `sram_en_o` out 1: SRAM enable.
- `sram_we_o` out `DATA_W/8`: SRAM byte write enables.
- `sram_addr_o` out `MEM_ADDR_W`: SRAM word address.
- `sram_wdata_o` out `DATA_W`: SRAM write data.
- `sram_rdata_i` in `DATA_W`: SRAM read data, valid the cycle after a read enable.
- `err_o` out 1: sticky address-range error.

## Operation
- FSM states: IDLE, WAIT, MEM, RDATA. Reset state is IDLE.
- IDLE: `iob_ready_o`=1. The block accepts a request on `iob_valid_i & iob_ready_o & cke_i`.
  - On accept, it latches the address, wdata and wstrb.
  - Next state is WAIT if `WAIT_CYCLES`>0, otherwise MEM.
- WAIT: `iob_ready_o`=0. A 4-bit counter loaded with `WAIT_CYCLES-1` decrements each cycle. The FSM goes to MEM when the counter is 0.
- MEM: `iob_ready_o`=0 and `sram_en_o`=1.
  - `sram_addr_o` = latched `addr[MEM_ADDR_W+1:2]`; `sram_we_o` = latched wstrb; `sram_wdata_o` = latched wdata.
  - Next state is IDLE for a write and RDATA for a read.
- RDATA: `iob_ready_o`=0. At the end of the cycle, `iob_rdata_o` loads `sram_rdata_i`, `iob_rvalid_o` is set for one cycle, and the FSM goes to IDLE.
- `iob_rdata_o` holds its value until the next read completes.
- Writes never assert `iob_rvalid_o`.
- Address bits [1:0] are ignored. Only word accesses are addressed; sub-word selection is done by the strobes.
- `iob_valid_i` while `iob_ready_o`=0 is ignored. The initiator must hold or re-present the request.
- `sram_en_o`, `sram_we_o` = 0 outside MEM. `sram_addr_o` and `sram_wdata_o` are driven from the latch at all times.

## Timing
- Reset values: `iob_ready_o`=1, `iob_rvalid_o`=0, `iob_rdata_o`=0, `sram_en_o`=0, `sram_we_o`=0, `sram_addr_o`=0, `sram_wdata_o`=0, `err_o`=0.
- Let T be the accept cycle and W = `WAIT_CYCLES`.
  - `sram_en_o` is high in cycle T+1+W.
  - Read: `iob_rvalid_o`=1 with valid `iob_rdata_o` in cycle T+3+W. `iob_ready_o` returns to 1 in that same cycle.
  - Write: `iob_ready_o` returns to 1 in cycle T+2+W. Any SRAM write completes at the edge ending T+1+W.
- Back-to-back: a new request may be accepted in the first cycle `iob_ready_o`=1, including the `rvalid` cycle.
  - Read throughput is one access per 3+W cycles; write throughput is one per 2+W cycles.
- `cke_i`=0 freezes state, counter, latches and outputs. An `rvalid` pulse then stretches until `cke_i` returns high.
- Reset asserted mid-transaction: the FSM goes immediately to IDLE, all outputs take their reset values, and the pending access is dropped with no SRAM enable.

## Configuration
- `IOB_SRAM_RESP_ADDR_CHECK_EN` defined:
  - A request whose address has any bit set above bit `MEM_ADDR_W+1` is out of range.
  - For an out-of-range request, MEM keeps `sram_en_o`=0 and `sram_we_o`=0.
  - An out-of-range read still returns `iob_rvalid_o` with `iob_rdata_o`=0. Timing is unchanged.
  - `err_o` is set one cycle after the MEM cycle and stays set until reset.
- Undefined: upper address bits are ignored, accesses alias modulo the SRAM depth, and `err_o` is tied 0.

## Test plan
- Reset and idle: release `arst_n_i` with no traffic -> `iob_ready_o`=1, `iob_rvalid_o`=0, `iob_rdata_o`=0, `sram_en_o`=0, `err_o`=0.
- Write then read, W=0: write 0xCAFEF00D to addr 0x10 with wstrb 0xF, then read 0x10.
  - Write: `sram_en_o` at T+1 with `sram_we_o`=0xF and `sram_addr_o`=4; `iob_ready_o`=1 at T+2.
  - Read: `iob_rvalid_o` at T+3 with `iob_rdata_o`=0xCAFEF00D.
- Wait states, W=3: read accepted at T -> `sram_en_o` only at T+4, `iob_rvalid_o` only at T+6, `iob_ready_o`=0 from T+1 through T+5.
- Partial write: write 0x11223344 to addr 0x20 with wstrb 0x3 over prior content 0xAABBCCDD -> `sram_we_o`=0x3; a later read returns 0xAABB3344. No `rvalid` is seen for the write.
- Stall and reset: hold `cke_i`=0 for 5 cycles during WAIT -> timing shifts by exactly 5 cycles. Assert `arst_n_i`=0 during MEM -> outputs return to reset values at once and no `rvalid` follows.
- With the macro defined, read addr 0x0000_1000 (out of range for `MEM_ADDR_W`=10) -> `sram_en_o` stays 0, `iob_rvalid_o` at T+3 with `iob_rdata_o`=0, `err_o`=1 thereafter. Without the macro, the same read returns word 0 and `err_o` stays 0.
